ext_bus_arbiter: RTL and testbench
==================================

Name: ext_bus_arbiter

Overview:
- Shares the single 32-bit external bus master port (header-plus-data protocol, cache-line bursts) between NUM_REQ on-chip requesters, e.g. icache, dcache and MMIO/uncached path.
- Grants one transaction at a time using round-robin, issues the header word, then sequences write-data or read-data beats to completion.
- Sits between the cache/MMIO miss logic and the external bus memory/peripheral slave.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WIDTH, 32, bus width; must be 32 because the header format is fixed.
- CLSIZE_E, 6, log2 cache-line bytes; a burst has BEATS = 2^(CLSIZE_E-2) words.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- IN_req  in  NUM_REQ  per-requester transaction request; held high until OUT_reqAck.
- IN_reqWrite  in  NUM_REQ  1 = write, 0 = read.
- IN_reqSize  in  2*NUM_REQ  size code; 3 = cache-line burst, else single word.
- IN_reqAddr  in  29*NUM_REQ  byte address.
- IN_wdata  in  WIDTH*NUM_REQ  current write word per requester.
- OUT_reqAck  out  NUM_REQ  one-cycle pulse when that requester's header is accepted.
- OUT_wdataPop  out  NUM_REQ  one-cycle pulse when that requester's current write word is consumed.
- OUT_rdata  out  WIDTH  read data, registered.
- OUT_rdataValid  out  NUM_REQ  one-hot read-beat strobe, registered.
- OUT_rdataLast  out  1  marks the final read beat of a transaction.
- OUT_busy  out  1  high in any state other than IDLE.
- OUT_busValid  out  1  bus valid.
- OUT_bus  out  WIDTH  header or write data.
- IN_busReady  in  1  slave ready.
- IN_bus  in  WIDTH  slave read data; valid during read phase.

Behaviour:
- Reset (rst = 0 at posedge):
  - state goes to IDLE; RR pointer = 0; beat counter = 0.
  - All outputs are 0, including OUT_bus.
  - Any in-flight transaction is abandoned with no ack or pop; the slave shares rst.
- Beat handshake: a beat completes when OUT_busValid && IN_busReady in the same cycle. OUT_busValid never drops mid-transaction.
- FSM states: IDLE, HDR, WDATA, RDATA.
- IDLE:
  - OUT_busValid = 0.
  - If any IN_req is high, select the first requester at or after the RR pointer (index wraps modulo NUM_REQ).
  - Latch grant index, write, size and addr; go to HDR next cycle.
- HDR:
  - OUT_busValid = 1; OUT_bus = {write, size[1:0], addr[28:0]}.
  - On beat: pulse OUT_reqAck[grant]; clear the beat counter.
  - Next state is WDATA if write, else RDATA.
- Beat count: size == 3 gives BEATS beats; any other size gives exactly 1 beat. The address is not incremented here; the slave increments it.
- WDATA:
  - OUT_busValid = 1; OUT_bus = IN_wdata[grant] (combinational).
  - On beat: pulse OUT_wdataPop[grant] in the same cycle; increment the counter.
  - Requester presents its next word by the following cycle.
- RDATA:
  - OUT_busValid = 1; OUT_bus = 0.
  - On beat: next cycle OUT_rdata = IN_bus sampled at the beat, OUT_rdataValid[grant] = 1, and OUT_rdataLast = 1 on the final beat. Latency is 1 cycle.
  - Increment the counter.
- Completion: after the final beat the state returns to IDLE, and the RR pointer becomes (grant + 1) mod NUM_REQ.
  - The next grant's earliest header therefore appears 2 cycles after the final beat (IDLE cycle, then HDR).
- Backpressure: with IN_busReady low, all outputs hold and no ack, pop or rdataValid is issued.
- Counter width is CLSIZE_E-2 bits; the final beat is counter == BEATS-1 (or 0 for single-word transactions). No wrap beyond that value.
- Request changes after grant, before ack, are ignored because the values are latched. Dropping IN_req before ack is illegal.
- A request arriving in the same cycle as a completion is only seen in IDLE the next cycle; no back-to-back header.

Test Plan:
- Req0 read, size 3, addr 0x0000_0100, IN_busReady = 1:
  - header 0x6000_0100 is driven;
  - 16 OUT_rdataValid[0] pulses follow, each 1 cycle after its beat;
  - OUT_rdataLast is high only on the 16th;
  - OUT_reqAck[0] pulses exactly once.
- Req2 write, size 0, addr 0x1000_0000, wdata 0x41:
  - header 0x9000_0000, then one data beat of 0x41;
  - exactly 1 OUT_wdataPop[2] pulse;
  - return to IDLE, OUT_busy = 0.
- All three requesters assert in the same cycle with pointer = 0:
  - grant order is 0, 1, 2;
  - re-asserting req0 during req1's transaction does not preempt it; req2 is served before req0.
- IN_busReady toggled pseudo-randomly (about 50%) during a size-3 write:
  - exactly 16 pops occur, in order;
  - OUT_bus is stable while ready is low;
  - no pop occurs in any ready-low cycle.
- rst driven low at read beat 7:
  - next cycle all outputs are 0 and state is IDLE;
  - no further rdataValid;
  - after rst is released, a new req1 is granted (pointer = 0 does not block it).

Source files
------------

// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter sharing one external header-plus-data bus master port
// between NUM_REQ requesters; sequences header, write beats and read beats.
module ext_bus_arbiter #(
   parameter int unsigned NUM_REQ  = 3,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CLSIZE_E = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         IN_req,
   input  logic [NUM_REQ-1:0]         IN_reqWrite,
   input  logic [2*NUM_REQ-1:0]       IN_reqSize,
   input  logic [29*NUM_REQ-1:0]      IN_reqAddr,
   input  logic [WIDTH*NUM_REQ-1:0]   IN_wdata,
   output logic [NUM_REQ-1:0]         OUT_reqAck,
   output logic [NUM_REQ-1:0]         OUT_wdataPop,
   output logic [WIDTH-1:0]           OUT_rdata,
   output logic [NUM_REQ-1:0]         OUT_rdataValid,
   output logic                       OUT_rdataLast,
   output logic                       OUT_busy,
   output logic                       OUT_busValid,
   output logic [WIDTH-1:0]           OUT_bus,
   input  logic                       IN_busReady,
   input  logic [WIDTH-1:0]           IN_bus
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = (CLSIZE_E > 2) ? CLSIZE_E - 2 : 1;
   localparam int unsigned BEATS = 1 << (CLSIZE_E - 2);

   typedef enum logic [1:0] {IDLE, HDR, WDATA, RDATA} state_t;

   // Latched transaction header; field order is the on-bus header layout.
   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic [28:0] addr;
   } hdr_t;

   state_t           state, nextState;
   hdr_t             curHdr;
   logic [IDX_W-1:0] grant, rrPtr, selIdx;
   logic             selFound;
   logic [CNT_W-1:0] beatCnt;
   logic             beat, lastBeat;

   function automatic logic [IDX_W-1:0] wrapIdx(input logic [31:0] v);
      return IDX_W'(v % NUM_REQ);
   endfunction

   assign beat     = (state != IDLE) && IN_busReady;
   assign lastBeat = (curHdr.size != 2'd3) || (beatCnt == CNT_W'(BEATS - 1));

   // Round-robin pick: first active request at or after the pointer.
   always_comb begin
      selFound = 1'b0;
      selIdx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!selFound && IN_req[wrapIdx(32'(rrPtr) + k)]) begin
            selFound = 1'b1;
            selIdx   = wrapIdx(32'(rrPtr) + k);
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   // Next state and bus-side outputs; ack/pop fire in the handshake cycle.
   always_comb begin
      nextState    = state;
      OUT_busValid = 1'b0;
      OUT_bus      = '0;
      OUT_reqAck   = '0;
      OUT_wdataPop = '0;
      OUT_busy     = (state != IDLE);
      case (state)
         IDLE: begin
            if (selFound) nextState = HDR;
         end
         HDR: begin
            OUT_busValid = 1'b1;
            OUT_bus      = WIDTH'(curHdr);
            if (beat) begin
               OUT_reqAck[grant] = 1'b1;
               nextState         = curHdr.write ? WDATA : RDATA;
            end
         end
         WDATA: begin
            OUT_busValid = 1'b1;
            OUT_bus      = IN_wdata[32'(grant)*WIDTH +: WIDTH];
            if (beat) begin
               OUT_wdataPop[grant] = 1'b1;
               if (lastBeat) nextState = IDLE;
            end
         end
         RDATA: begin
            OUT_busValid = 1'b1;
            if (beat && lastBeat) nextState = IDLE;
         end
      endcase
   end

   // Grant/header latch, beat counter, RR pointer and registered read return.
   always_ff @(posedge clk) begin
      if (!rst) begin
         grant          <= '0;
         rrPtr          <= '0;
         curHdr         <= '0;
         beatCnt        <= '0;
         OUT_rdata      <= '0;
         OUT_rdataValid <= '0;
         OUT_rdataLast  <= 1'b0;
      end else begin
         OUT_rdataValid <= '0;
         OUT_rdataLast  <= 1'b0;
         case (state)
            IDLE: begin
               if (selFound) begin
                  grant  <= selIdx;
                  curHdr <= hdr_t'({IN_reqWrite[selIdx],
                                    IN_reqSize[2*32'(selIdx) +: 2],
                                    IN_reqAddr[29*32'(selIdx) +: 29]});
               end
            end
            HDR: begin
               if (beat) beatCnt <= '0;
            end
            WDATA, RDATA: begin
               if (beat) begin
                  if (state == RDATA) begin
                     OUT_rdata             <= IN_bus;
                     OUT_rdataValid[grant] <= 1'b1;
                     OUT_rdataLast         <= lastBeat;
                  end
                  if (lastBeat) rrPtr   <= wrapIdx(32'(grant) + 1);
                  else          beatCnt <= beatCnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Self-checking bench: requester/slave models feed a scoreboard of expected
// headers, write words and read returns; table vectors plus corner sequences.
module tb_ext_bus_arbiter;

   localparam int unsigned NUM_REQ  = 3;
   localparam int unsigned WIDTH    = 32;
   localparam int unsigned CLSIZE_E = 6;
   localparam int          BEATS    = 16;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic [NUM_REQ-1:0]       IN_req = '0;
   logic [NUM_REQ-1:0]       IN_reqWrite = '0;
   logic [2*NUM_REQ-1:0]     IN_reqSize = '0;
   logic [29*NUM_REQ-1:0]    IN_reqAddr = '0;
   logic [WIDTH*NUM_REQ-1:0] IN_wdata = '0;
   logic [NUM_REQ-1:0]       OUT_reqAck, OUT_wdataPop, OUT_rdataValid;
   logic [WIDTH-1:0]         OUT_rdata, OUT_bus;
   logic                     OUT_rdataLast, OUT_busy, OUT_busValid;
   logic                     IN_busReady = 1'b0;
   logic [WIDTH-1:0]         IN_bus = '0;

   ext_bus_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CLSIZE_E(CLSIZE_E)) dut (
      .clk(clk), .rst(rst),
      .IN_req(IN_req), .IN_reqWrite(IN_reqWrite), .IN_reqSize(IN_reqSize),
      .IN_reqAddr(IN_reqAddr), .IN_wdata(IN_wdata),
      .OUT_reqAck(OUT_reqAck), .OUT_wdataPop(OUT_wdataPop),
      .OUT_rdata(OUT_rdata), .OUT_rdataValid(OUT_rdataValid),
      .OUT_rdataLast(OUT_rdataLast), .OUT_busy(OUT_busy),
      .OUT_busValid(OUT_busValid), .OUT_bus(OUT_bus),
      .IN_busReady(IN_busReady), .IN_bus(IN_bus)
   );

   always #5 clk = ~clk;

   typedef struct { int idx; logic [31:0] hdr; bit wr; int beats; } hdrE_t;
   typedef struct { int idx; logic [31:0] word; } wrE_t;
   typedef struct { int idx; logic [31:0] data; bit last; int cyc; } rdE_t;
   typedef struct { int idx; bit wr; bit [1:0] size; bit [28:0] addr;
                    int unsigned rdy; bit [31:0] hdr; bit [31:0] wd; } vec_t;

   int nTests = 0, nFail = 0, cyc = 0;

   // requester model state
   bit          reqPend [NUM_REQ];
   bit          reqWrite[NUM_REQ];
   bit [1:0]    reqSize [NUM_REQ];
   bit [28:0]   reqAddr [NUM_REQ];
   logic [31:0] wq      [NUM_REQ][$];
   int unsigned rdyPct = 100;

   // scoreboard queues and slave model
   hdrE_t expHdr[$];
   wrE_t  expWr[$];
   rdE_t  expRd[$];
   hdrE_t he;
   wrE_t  we;
   rdE_t  re;
   int    slvPhase = 0, slvLeft = 0, slvDone = 0, slvOwner = 0, lastFinalCyc = -1;
   bit    prevStall = 0;
   logic [31:0] prevBus = '0;
   int    ackCnt[NUM_REQ], popCnt[NUM_REQ], rdvCnt[NUM_REQ];
   int    lastCnt = 0;

   logic beat;
   assign beat = OUT_busValid && IN_busReady;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic failNow(input string name);
      nTests++;
      nFail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   always @(posedge clk) cyc++;

   // Drive requester and slave inputs just after each rising edge.
   initial forever begin
      @(posedge clk);
      #1;
      IN_busReady = (rdyPct >= 100) ? 1'b1 : ($urandom_range(99) < rdyPct);
      IN_bus      = $urandom;
      for (int i = 0; i < NUM_REQ; i++) begin
         IN_req[i]            = reqPend[i];
         IN_reqWrite[i]       = reqWrite[i];
         IN_reqSize[2*i +: 2] = reqSize[i];
         IN_reqAddr[29*i +: 29] = reqAddr[i];
         IN_wdata[32*i +: 32] = (wq[i].size() != 0) ? wq[i][0] : (32'hBAD0_0000 | 32'(i));
      end
   end

   // Monitor: slave-side protocol model and scoreboard checks.
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (OUT_reqAck[i])     ackCnt[i]++;
            if (OUT_wdataPop[i])   popCnt[i]++;
            if (OUT_rdataValid[i]) rdvCnt[i]++;
         end
         if (OUT_rdataLast) lastCnt++;
         if (prevStall) begin
            chk("stallBus", OUT_bus, prevBus);
            chk("stallValid", 32'(OUT_busValid), 32'd1);
         end
         if (!beat) chk("ackPopNoBeat", 32'({OUT_reqAck, OUT_wdataPop}), 32'd0);
         if (expRd.size() != 0 && expRd[0].cyc + 1 == cyc) begin
            re = expRd.pop_front();
            chk("rdValid", 32'(OUT_rdataValid), 32'(1 << re.idx));
            chk("rdata", OUT_rdata, re.data);
            chk("rdLast", 32'(OUT_rdataLast), 32'(re.last));
         end else begin
            chk("rdIdle", 32'({OUT_rdataValid, OUT_rdataLast}), 32'd0);
         end
         if (beat) begin
            case (slvPhase)
               0: begin
                  if (expHdr.size() == 0) failNow("hdrUnexpected");
                  else begin
                     he = expHdr.pop_front();
                     chk("hdrAck", 32'(OUT_reqAck), 32'(1 << he.idx));
                     chk("hdrWord", OUT_bus, he.hdr);
                     if (lastFinalCyc >= 0) chk("hdrGap", 32'(cyc - lastFinalCyc >= 2), 32'd1);
                     reqPend[he.idx] = 0;
                     slvOwner = he.idx;
                     slvLeft  = he.beats;
                     slvDone  = 0;
                     slvPhase = he.wr ? 1 : 2;
                  end
               end
               1: begin
                  if (expWr.size() == 0) failNow("wrUnexpected");
                  else begin
                     we = expWr.pop_front();
                     chk("popOwner", 32'(OUT_wdataPop), 32'(1 << we.idx));
                     chk("wdata", OUT_bus, we.word);
                  end
                  if (wq[slvOwner].size() != 0) void'(wq[slvOwner].pop_front());
               end
               default: begin
                  expRd.push_back('{slvOwner, IN_bus, slvLeft == 1, cyc});
                  chk("rdBusZero", OUT_bus, 32'd0);
               end
            endcase
            if (slvPhase != 0 && !(slvPhase != 0 && slvDone == 0 && OUT_reqAck != 0)) begin
               slvLeft--;
               slvDone++;
               if (slvLeft == 0) begin
                  slvPhase     = 0;
                  lastFinalCyc = cyc;
               end
            end
         end
         prevStall = OUT_busValid && !IN_busReady;
         prevBus   = OUT_bus;
      end
   end

   task automatic issue(input int i, input bit wr, input bit [1:0] sz, input bit [28:0] ad,
                        input bit [31:0] hdr, input bit [31:0] wd);
      int n;
      n = (sz == 2'd3) ? BEATS : 1;
      expHdr.push_back('{i, hdr, wr, n});
      reqWrite[i] = wr;
      reqSize[i]  = sz;
      reqAddr[i]  = ad;
      if (wr) begin
         for (int k = 0; k < n; k++) begin
            wq[i].push_back(wd + 32'(k));
            expWr.push_back('{i, wd + 32'(k)});
         end
      end
      reqPend[i] = 1;
   endtask

   function automatic bit idleNow();
      bit any = 0;
      for (int i = 0; i < NUM_REQ; i++) any |= reqPend[i];
      return !any && expHdr.size() == 0 && expWr.size() == 0 && expRd.size() == 0 &&
             slvPhase == 0 && !OUT_busy && OUT_rdataValid == 0;
   endfunction

   task automatic waitIdle(input int maxCyc, input string tag);
      int k;
      for (k = 0; k < maxCyc; k++) begin
         tick();
         if (idleNow()) break;
      end
      if (k == maxCyc) failNow({"timeout_", tag});
   endtask

   task automatic clearModel();
      for (int i = 0; i < NUM_REQ; i++) begin
         reqPend[i] = 0;
         wq[i].delete();
      end
      expHdr.delete();
      expWr.delete();
      expRd.delete();
      slvPhase = 0; slvLeft = 0; slvDone = 0;
      prevStall = 0;
      lastFinalCyc = -1;
   endtask

   task automatic chkZero(input string tag);
      chk({tag, "_busValid"}, 32'(OUT_busValid), 32'd0);
      chk({tag, "_bus"}, OUT_bus, 32'd0);
      chk({tag, "_ackPop"}, 32'({OUT_reqAck, OUT_wdataPop}), 32'd0);
      chk({tag, "_rdata"}, OUT_rdata, 32'd0);
      chk({tag, "_rdv"}, 32'({OUT_rdataValid, OUT_rdataLast}), 32'd0);
      chk({tag, "_busy"}, 32'(OUT_busy), 32'd0);
   endtask

   vec_t vecs[6];

   initial begin
      int a0, p0, r0, l0, a1, a2, n, k, idx, saved0, r1;
      vecs[0] = '{0, 1'b0, 2'd3, 29'h0000_0100, 100, 32'h6000_0100, 32'h0};
      vecs[1] = '{2, 1'b1, 2'd0, 29'h1000_0000, 100, 32'h9000_0000, 32'h41};
      vecs[2] = '{1, 1'b1, 2'd3, 29'h0000_0040,  50, 32'hE000_0040, 32'hA000_0000};
      vecs[3] = '{1, 1'b0, 2'd1, 29'h0ABC_DEF0,  50, 32'h2ABC_DEF0, 32'h0};
      vecs[4] = '{0, 1'b1, 2'd2, 29'h1FFF_FFFC, 100, 32'hDFFF_FFFC, 32'h5555_0000};
      vecs[5] = '{2, 1'b0, 2'd3, 29'h0000_0200,  50, 32'h6000_0200, 32'h0};
      for (int i = 0; i < NUM_REQ; i++) begin
         reqPend[i] = 0; reqWrite[i] = 0; reqSize[i] = 0; reqAddr[i] = 0;
         ackCnt[i] = 0; popCnt[i] = 0; rdvCnt[i] = 0;
      end

      // reset state
      rst = 1'b0;
      repeat (3) tick();
      chkZero("reset");
      rst = 1'b1;
      tick();

      // three simultaneous requests from pointer 0; req0 re-asserted mid req1
      rdyPct = 100;
      issue(0, 1'b0, 2'd3, 29'h400, {1'b0, 2'd3, 29'h400}, 32'h0);
      issue(1, 1'b0, 2'd3, 29'h500, {1'b0, 2'd3, 29'h500}, 32'h0);
      issue(2, 1'b0, 2'd3, 29'h600, {1'b0, 2'd3, 29'h600}, 32'h0);
      a0 = ackCnt[0]; a1 = ackCnt[1]; a2 = ackCnt[2];
      for (k = 0; k < 500 && ackCnt[1] == a1; k++) tick();
      if (k == 500) failNow("timeout_req1Ack");
      issue(0, 1'b1, 2'd0, 29'h700, {1'b1, 2'd0, 29'h700}, 32'hCAFE_0000);
      waitIdle(3000, "rr");
      chk("rr_ack0", 32'(ackCnt[0] - a0), 32'd2);
      chk("rr_ack1", 32'(ackCnt[1] - a1), 32'd1);
      chk("rr_ack2", 32'(ackCnt[2] - a2), 32'd1);

      // table-driven single transactions
      for (int v = 0; v < 6; v++) begin
         idx = vecs[v].idx;
         rdyPct = vecs[v].rdy;
         a0 = ackCnt[idx]; p0 = popCnt[idx]; r0 = rdvCnt[idx]; l0 = lastCnt;
         issue(idx, vecs[v].wr, vecs[v].size, vecs[v].addr, vecs[v].hdr, vecs[v].wd);
         waitIdle(2000, $sformatf("vec%0d", v));
         n = (vecs[v].size == 2'd3) ? BEATS : 1;
         chk($sformatf("vec%0d_ack", v), 32'(ackCnt[idx] - a0), 32'd1);
         if (vecs[v].wr) begin
            chk($sformatf("vec%0d_pops", v), 32'(popCnt[idx] - p0), 32'(n));
         end else begin
            chk($sformatf("vec%0d_rdv", v), 32'(rdvCnt[idx] - r0), 32'(n));
            chk($sformatf("vec%0d_last", v), 32'(lastCnt - l0), 32'd1);
         end
         chk($sformatf("vec%0d_busy", v), 32'(OUT_busy), 32'd0);
      end

      // reset in the middle of a read burst
      rdyPct = 100;
      issue(0, 1'b0, 2'd3, 29'h300, {1'b0, 2'd3, 29'h300}, 32'h0);
      for (k = 0; k < 500 && !(slvPhase == 2 && slvDone == 7); k++) tick();
      if (k == 500) failNow("timeout_beat7");
      rst = 1'b0;
      tick();
      clearModel();
      chkZero("rstMid");
      saved0 = rdvCnt[0];
      rst = 1'b1;
      tick();
      a1 = ackCnt[1]; r1 = rdvCnt[1];
      issue(1, 1'b0, 2'd0, 29'h44, {1'b0, 2'd0, 29'h44}, 32'h0);
      waitIdle(500, "postRst");
      chk("postRst_ack1", 32'(ackCnt[1] - a1), 32'd1);
      chk("postRst_rdv1", 32'(rdvCnt[1] - r1), 32'd1);
      chk("postRst_noRdv0", 32'(rdvCnt[0]), 32'(saved0));

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
